display_scheduler: RTL
======================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter WORDS, default 4: BCD digits per display frame.
REQ-002 The block SHALL have parameter BIT_DIV, default 4000 (legal values are even and >= 4): internal_clock cycles per serial bit period.
REQ-003 The block SHALL have port internal_clock, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, 4 bits: req[i] is a frame request from requester i, level-sensitive.
REQ-006 The block SHALL have port value, input, 16*WORDS bits: requester i's BCD word sits at [4*WORDS*i +: 4*WORDS], with nibble 0 at LSBs.
REQ-007 The block SHALL have port ack, output, 4 bits: a one-cycle pulse on ack[owner] when that owner's frame completes.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-009 The block SHALL have port cur_owner, output, 2 bits: index of the requester currently granted.
REQ-010 The block SHALL have ports VALUE_SIGNAL, ENABLE_SIGNAL and DATA_CLOCK_SIGNAL, each output, 1 bit: the serial display data, the frame enable and the bit clock.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT, GAP and DONE, all registered.
REQ-012 In IDLE, when any req bit is high, the block SHALL grant round-robin starting from (last_owner+1) mod 4, latch that requester's value into the shift register in the same cycle, and enter SHIFT.
REQ-013 The block SHALL update cur_owner and last_owner at the grant, clear the bit prescaler to 0, and drive busy=1 from the cycle after the grant through the DONE cycle inclusive.
REQ-014 The block SHALL use a prescaler that counts 0..BIT_DIV-1 in SHIFT and GAP; a bit boundary occurs when the count wraps.
REQ-015 DATA_CLOCK_SIGNAL SHALL be 1 while prescaler < BIT_DIV/2 in SHIFT and GAP, and 0 in IDLE and DONE.
REQ-016 In SHIFT, bit k (k = 0..4*WORDS-1) SHALL drive VALUE_SIGNAL = frame[(3 - k%4) + 4*(k/4)], i.e. nibble 0 first with the MSB of each nibble first.
REQ-017 In SHIFT, ENABLE_SIGNAL SHALL be 1, and each bit SHALL be held for exactly BIT_DIV cycles.
REQ-018 The first bit SHALL appear on VALUE_SIGNAL in the cycle after the grant.
REQ-019 Any latched nibble greater than 9 SHALL be transmitted as 4'hF, the blank code; valid nibbles SHALL pass unchanged.
REQ-020 After the last SHIFT bit, the block SHALL enter GAP for 4*WORDS bit periods with VALUE_SIGNAL=0 and ENABLE_SIGNAL=0.
REQ-021 After GAP, the block SHALL enter DONE for one cycle, pulse ack[cur_owner], and return to IDLE.
REQ-022 Arbitration SHALL occur only in IDLE, so frames are separated by at least one IDLE cycle.
REQ-023 Changes on value or req during SHIFT or GAP SHALL be ignored; the latched frame completes and is acked even if req dropped.
REQ-024 A requester holding req after its ack SHALL be rescheduled behind all other pending requesters.

Reset
REQ-025 When RST is high, the block SHALL immediately force IDLE, prescaler=0, last_owner=3, cur_owner=0, busy=0, ack=0, VALUE_SIGNAL=0, ENABLE_SIGNAL=0 and DATA_CLOCK_SIGNAL=0.
REQ-026 A reset during SHIFT or GAP SHALL abort the frame with no ack; after release, req[0] has highest priority.

Verification (WORDS=4, BIT_DIV=4)
REQ-027 The bench SHALL cover this scenario: req[0]=1 with value[15:0]=16'h1234 granted at cycle n -> VALUE_SIGNAL serial sequence 0100 0011 0010 0001 from n+1, ENABLE_SIGNAL high for 64 cycles then low for 64, and ack[0] pulses once at n+129.
REQ-028 The bench SHALL cover this scenario: req[0] and req[2] held continuously -> grant order 0,2,0,2, and busy drops for exactly one cycle between frames.
REQ-029 The bench SHALL cover this scenario: value[15:0]=16'h00A5 -> serial sequence 0101 1111 0000 0000, with nibble A replaced by F.
REQ-030 The bench SHALL cover this scenario: RST pulsed mid-SHIFT of a requester-2 frame -> all outputs 0 asynchronously and no ack[2]; with req[1] and req[3] pending afterwards, requester 1 is served first.
REQ-031 The bench SHALL cover this scenario: req[3] dropped and value changed during SHIFT -> the original word is fully transmitted and ack[3] still pulses.
REQ-032 The bench SHALL cover this scenario: all four req high from reset -> owners served 0,1,2,3,0, and cur_owner matches ack each time.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin arbiter for four requesters, each owning a
// BCD word that is serialised to a display as one frame (SHIFT), followed by
// an equally long quiet period (GAP) and a single-cycle completion ack (DONE).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for any req; grants and latches the word on the same edge
// SHIFT | serialising 4*WORDS bits, BIT_DIV cycles each, enable high
// GAP   | 4*WORDS silent bit periods, data and enable low, bit clock runs
// DONE  | one cycle, ack[cur_owner] pulses, then back to IDLE
module display_scheduler #(
  parameter int WORDS   = 4,
  parameter int BIT_DIV = 4000
) (
  input  logic                  internal_clock,
  input  logic                  RST,
  input  logic [3:0]            req,
  input  logic [16*WORDS-1:0]   value,
  output logic [3:0]            ack,
  output logic                  busy,
  output logic [1:0]            cur_owner,
  output logic                  VALUE_SIGNAL,
  output logic                  ENABLE_SIGNAL,
  output logic                  DATA_CLOCK_SIGNAL
);

  localparam int NBITS = 4 * WORDS;
  localparam int PW    = $clog2(BIT_DIV);
  localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(BIT_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(BIT_DIV / 2);
  localparam logic [BW-1:0] BITS_LAST  = BW'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_presc;
  logic [BW-1:0]     r_bits;
  logic [NBITS-1:0]  r_shift;
  logic [1:0]        r_owner;
  logic [1:0]        r_last;

  logic              w_any;
  logic [1:0]        w_grant;
  logic [NBITS-1:0]  w_raw;
  logic [NBITS-1:0]  w_load;
  logic [3:0]        w_nib;
  logic              w_bit_end;
  logic              w_last_bit;

  assign w_bit_end  = (r_presc == PRESC_LAST);
  assign w_last_bit = (r_bits == '0);

  // Round-robin pick: scan offsets 4..1 so the smallest offset past last owner wins;
  // offset 4 wraps to last owner itself, which therefore ranks behind everyone else.
  always_comb begin
    w_any   = |req;
    w_grant = r_last + 2'd1;
    for (int off = 4; off >= 1; off--) begin
      if (req[r_last + 2'(off)]) begin
        w_grant = r_last + 2'(off);
      end
    end
  end

  // Select the granted word, blank invalid BCD digits, and reorder so the
  // shift register MSB is always the next bit (nibble 0 first, nibble MSB first).
  always_comb begin
    w_raw  = '0;
    w_load = '0;
    w_nib  = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_grant == 2'(i)) begin
        w_raw = value[NBITS*i +: NBITS];
      end
    end
    for (int n = 0; n < WORDS; n++) begin
      w_nib = w_raw[4*n +: 4];
      if (w_nib > 4'd9) begin
        w_nib = 4'hF;
      end
      for (int j = 0; j < 4; j++) begin
        w_load[NBITS-1-(4*n+3-j)] = w_nib[j];
      end
    end
  end

  // State register.
  always_ff @(posedge internal_clock or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; SHIFT and GAP both last NBITS bit periods.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_SHIFT;
      S_SHIFT: if (w_bit_end && w_last_bit) w_next = S_GAP;
      S_GAP:   if (w_bit_end && w_last_bit) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: grant/latch in IDLE, prescaler and bit down-counter in SHIFT/GAP.
  always_ff @(posedge internal_clock or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
      r_bits  <= BITS_LAST;
      r_shift <= '0;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_shift <= w_load;
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_presc <= '0;
            r_bits  <= BITS_LAST;
          end
        end
        S_SHIFT, S_GAP: begin
          if (w_bit_end) begin
            r_presc <= '0;
            r_shift <= {r_shift[NBITS-2:0], 1'b0};
            r_bits  <= w_last_bit ? BITS_LAST : r_bits - 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state, so reset clears them immediately.
  always_comb begin
    ack               = '0;
    busy              = (r_state != S_IDLE);
    cur_owner         = r_owner;
    ENABLE_SIGNAL     = (r_state == S_SHIFT);
    VALUE_SIGNAL      = (r_state == S_SHIFT) && r_shift[NBITS-1];
    DATA_CLOCK_SIGNAL = ((r_state == S_SHIFT) || (r_state == S_GAP)) && (r_presc < PRESC_HALF);
    if (r_state == S_DONE) begin
      ack[r_owner] = 1'b1;
    end
  end

endmodule
